// File: rtl/transceiver_ack_scheduler_if.sv
// transceiver_ack_scheduler_if: ID-result FIFO, DLLP buffer and status signals of the ACK scheduler
interface transceiver_ack_scheduler_if #(
  parameter int TLP_ID_WIDTH = 3,
  parameter int DLLP_WIDTH   = 16
);
  logic                    i_enable;
  logic                    i_id_result_valid;
  logic [TLP_ID_WIDTH:0]   i_id_result;
  logic                    o_id_result_rd;
  logic                    i_dllp_rdy;
  logic [DLLP_WIDTH-1:0]   o_dllp;
  logic                    o_dllp_wr;
  logic                    o_ack_pending;
  logic [7:0]              o_nack_cnt;
  modport slave (
    input  i_enable, i_id_result_valid, i_id_result, i_dllp_rdy,
    output o_id_result_rd, o_dllp, o_dllp_wr, o_ack_pending, o_nack_cnt
  );
  modport master (
    output i_enable, i_id_result_valid, i_id_result, i_dllp_rdy,
    input  o_id_result_rd, o_dllp, o_dllp_wr, o_ack_pending, o_nack_cnt
  );
endinterface

// File: rtl/transceiver_ack_scheduler.sv
// transceiver_ack_scheduler: coalesces good TLP results into ACK DLLPs and reports bad ones with one NACK per episode
module transceiver_ack_scheduler #(
  parameter int TLP_ID_WIDTH = 3,
  parameter int DLLP_WIDTH   = 16,
  parameter int ACK_COALESCE = 4,
  parameter int ACK_TIMEOUT  = 64
) (
  input logic                   i_sys_clk_120,
  input logic                   i_sys_rst,
  transceiver_ack_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COLLECT, SEND_ACK, SEND_NACK, NACK_HOLD} state_t;
  state_t state, nxt_state;
  logic [7:0] cnt, nxt_cnt, nack_cnt;
  logic [15:0] timer, nxt_timer;
  logic [TLP_ID_WIDTH-1:0] last_id, nxt_last, id;
  logic [DLLP_WIDTH-1:0] dllp, ack_word, nack_word;
  logic rx, pop, ok, timeout, pending;
  assign rx = state inside {IDLE, COLLECT, NACK_HOLD};
  assign pop = bus.i_id_result_valid & bus.i_enable & rx & ~i_sys_rst;
  assign ok = bus.i_id_result[TLP_ID_WIDTH];
  assign id = bus.i_id_result[TLP_ID_WIDTH-1:0];
  assign timeout = state == COLLECT && timer == 16'(ACK_TIMEOUT - 1);
  assign bus.o_id_result_rd = pop;
  // Write strobe is qualified by rdy in the same cycle, so it can never be high against a busy buffer
  assign bus.o_dllp_wr = (state == SEND_ACK || state == SEND_NACK) && bus.i_dllp_rdy && !i_sys_rst;
  assign bus.o_dllp = dllp;
  assign bus.o_ack_pending = pending;
  assign bus.o_nack_cnt = nack_cnt;
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    nxt_timer = timer;
    nxt_last = last_id;
    if (rx && !bus.i_enable) begin
      nxt_state = IDLE;
      nxt_cnt = '0;
      nxt_timer = '0;
      nxt_last = '1;
    end else if (pop && !ok) begin
      if (state != NACK_HOLD) begin
        nxt_state = SEND_NACK;
        nxt_cnt = '0;
        nxt_timer = '0;
      end
    end else if (pop) begin
      nxt_last = id;
      nxt_cnt = state == COLLECT ? cnt + 8'd1 : 8'd1;
      nxt_timer = state == COLLECT ? timer + 16'd1 : 16'd0;
      nxt_state = (nxt_cnt == 8'(ACK_COALESCE) || timeout) ? SEND_ACK : COLLECT;
    end else if (state == COLLECT) begin
      nxt_timer = timer + 16'd1;
      nxt_state = timeout ? SEND_ACK : COLLECT;
    end else if (state == SEND_ACK && bus.i_dllp_rdy) begin
      nxt_state = IDLE;
      nxt_cnt = '0;
      nxt_timer = '0;
    end else if (state == SEND_NACK && bus.i_dllp_rdy) begin
      nxt_state = NACK_HOLD;
    end
  end
  always_comb begin
    ack_word = '0;
    ack_word[DLLP_WIDTH-1 -: 8] = 8'h01;
    ack_word[TLP_ID_WIDTH-1:0] = nxt_last;
    nack_word = '0;
    nack_word[DLLP_WIDTH-1 -: 8] = 8'h02;
    nack_word[TLP_ID_WIDTH-1:0] = last_id;
  end
  // The DLLP word is loaded on entry to a SEND state so it is stable for the whole wait on rdy
  always_ff @(posedge i_sys_clk_120) begin
    if (i_sys_rst) begin
      state <= IDLE;
      cnt <= '0;
      timer <= '0;
      last_id <= '1;
      dllp <= '0;
      pending <= 1'b0;
      nack_cnt <= '0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      timer <= nxt_timer;
      last_id <= nxt_last;
      pending <= nxt_state == COLLECT;
      dllp <= (nxt_state == SEND_ACK && state != SEND_ACK) ? ack_word :
              (nxt_state == SEND_NACK && state != SEND_NACK) ? nack_word : dllp;
      nack_cnt <= (state == SEND_NACK && bus.i_dllp_rdy && nack_cnt != 8'hff) ? nack_cnt + 8'd1 : nack_cnt;
    end
  end
endmodule

// File: doc/transceiver_ack_scheduler.md
TRANSCEIVER_ACK_SCHEDULER -- requirements
Module: transceiver_ack_scheduler

Interface
REQ-001 Parameter TLP_ID_WIDTH, default 3; width of the TLP sequence ID.
REQ-002 Parameter DLLP_WIDTH, default 16; width of the generated DLLP word.
REQ-003 Parameter ACK_COALESCE, default 4; number of good TLPs (range 1..255) that triggers an immediate ACK.
REQ-004 Parameter ACK_TIMEOUT, default 64; cycles (range 2..65535) that a pending ACK may wait in COLLECT.
REQ-005 One clock; reset is synchronous and active-high: i_sys_clk_120 input 1, system clock; i_sys_rst input 1, synchronous active-high reset.
REQ-006 i_enable  input  1  link connected; gates all result consumption.
REQ-007 i_id_result_valid  input  1  receiver ID-result FIFO non-empty (show-ahead).
REQ-008 i_id_result  input  TLP_ID_WIDTH+1  {ok, id}; ok=1 means CRC and sequence are good.
REQ-009 o_id_result_rd  output  1  pop strobe; the result is consumed on the edge where it is high.
REQ-010 i_dllp_rdy  input  1  transmitter DLLP buffer can accept a word.
REQ-011 o_dllp  output  DLLP_WIDTH  {type[7:0], zero pad, id}; type ACK=8'h01, NACK=8'h02.
REQ-012 o_dllp_wr  output  1  one-cycle write strobe for o_dllp.
REQ-013 o_ack_pending  output  1  high while good TLPs are unacknowledged (state COLLECT).
REQ-014 o_nack_cnt  output  8  saturating count of NACKs sent.

Function
REQ-015 The FSM SHALL use the states IDLE, COLLECT, SEND_ACK, SEND_NACK and NACK_HOLD.
REQ-016 o_id_result_rd SHALL equal i_id_result_valid AND i_enable AND state in {IDLE, COLLECT, NACK_HOLD}; back-to-back pops are allowed.
REQ-017 last_id (TLP_ID_WIDTH bits) SHALL reset to all ones; each consumed good result SHALL load last_id with its id.
REQ-018 Good result in IDLE: go to COLLECT, set cnt=1, set timer=0; if ACK_COALESCE==1, go to SEND_ACK instead.
REQ-019 Good result in COLLECT: cnt increments; when cnt+1==ACK_COALESCE, go to SEND_ACK.
REQ-020 Timer in COLLECT: increments each cycle; when timer==ACK_TIMEOUT-1, go to SEND_ACK.
REQ-021 Good result and timeout in the same cycle: the result is counted first, then SEND_ACK with the new last_id.
REQ-022 Bad result (ok=0) in IDLE or COLLECT: go to SEND_NACK; clear cnt and timer; last_id is unchanged.
REQ-023 SEND_ACK: when i_dllp_rdy=1, pulse o_dllp_wr with o_dllp={8'h01, last_id}, then go to IDLE with cnt=0 and timer=0; wait indefinitely while i_dllp_rdy=0.
REQ-024 SEND_NACK: when i_dllp_rdy=1, pulse o_dllp_wr with o_dllp={8'h02, last_id}, increment o_nack_cnt (saturate at 255), then go to NACK_HOLD.
REQ-025 NACK_HOLD: bad results are popped and dropped with no further NACK; a good result goes to COLLECT with cnt=1, timer=0 and last_id=id.
REQ-026 i_enable=0 in IDLE, COLLECT or NACK_HOLD: go to IDLE next cycle, clear cnt and timer, set last_id to all ones.
REQ-027 SEND_ACK and SEND_NACK SHALL complete regardless of i_enable.
REQ-028 o_dllp SHALL be registered and hold its last value between writes.
REQ-029 At most one o_dllp_wr pulse SHALL occur per SEND state visit.
REQ-030 o_dllp_wr SHALL never be high while i_dllp_rdy is low.
REQ-031 ID arithmetic is modulo 2^TLP_ID_WIDTH; last_id wraps 7->0 with no special handling.

Reset
REQ-032 i_sys_rst=1 sampled on a clock edge: state=IDLE, cnt=0, timer=0, last_id=all ones, o_dllp=0, o_dllp_wr=0, o_ack_pending=0, o_nack_cnt=0.
REQ-033 During reset o_id_result_rd SHALL be 0; reset asserted mid-SEND aborts without a write.

Verification
REQ-034 Four good ids 0..3 back-to-back, rdy=1 -> exactly one o_dllp_wr, o_dllp=16'h0103, 4 pops.
REQ-035 One good id 5, then no traffic -> ACK 16'h0105 written 64 cycles after the pop; o_ack_pending high until then.
REQ-036 Good ids 0,1, then bad, bad, then good 2 -> one NACK 16'h0201, o_nack_cnt=1, both bad results popped, then COLLECT with last_id=2.
REQ-037 SEND_ACK with i_dllp_rdy=0 for 10 cycles -> no pops, no write; write occurs on the first rdy=1 cycle.
REQ-038 Good ids 6,7,0,1 -> ACK 16'h0101 (wrap); then i_enable=0 in COLLECT -> IDLE, last_id=7, no DLLP.
REQ-039 300 NACK episodes -> o_nack_cnt saturates at 255.
